// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed restoring divider (2W/W bits); DIV_EARLY_ZERO_EN skips CALC when b==0
module div_seq #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]     rem,
   output logic                 busy,
   output logic                 done,
   output logic                 div_zero,
   output logic                 ovf
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nxt;
   logic   accept;

   // operands captured on an accepted start
   logic [DW-1:0]    a_r;
   logic [WIDTH-1:0] b_r;

   // restoring-division working set; q_sh shifts |a| out and quotient bits in
   logic             sign_a, sign_b;
   logic [DW-1:0]    q_sh;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH:0]   prem;
   logic [CW-1:0]    cnt;

   // |b| can reach 2^(WIDTH-1), so it is formed at WIDTH+1 bits from a sign-extended copy
   logic [WIDTH:0]   b_ext;
   // one extra bit above the partial remainder makes the trial borrow visible
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic [DW-1:0]    q_signed;
   logic [WIDTH-1:0] r_signed;
   logic             b_is_zero;
   logic             is_ovf;

   assign b_ext     = {b_r[WIDTH-1], b_r};
   assign shifted   = {prem, q_sh[DW-1]};
   assign trial     = shifted - {1'b0, b_mag};
   assign q_signed  = (sign_a ^ sign_b) ? -q_sh : q_sh;
   assign r_signed  = sign_a ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
   assign b_is_zero = (b_r == '0);
   // only most-negative / -1 yields a quotient magnitude outside the signed range
   assign is_ovf    = (a_r == {1'b1, {(DW-1){1'b0}}}) && (b_r == '1);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state, start acceptance and status outputs
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_PREP;
            end
         end
         S_PREP: begin
            busy = 1'b1;
`ifdef DIV_EARLY_ZERO_EN
            state_nxt = b_is_zero ? S_FIX : S_CALC;
`else
            state_nxt = S_CALC;
`endif
         end
         S_CALC: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = S_FIX;
         end
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_PREP;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // operand capture, one quotient bit per CALC cycle, signed result registration in FIX
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         q_sh     <= '0;
         b_mag    <= '0;
         prem     <= '0;
         cnt      <= '0;
         quot     <= '0;
         rem      <= '0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (accept) begin
            a_r <= a;
            b_r <= b;
         end
         case (state)
            S_PREP: begin
               sign_a <= a_r[DW-1];
               sign_b <= b_r[WIDTH-1];
               q_sh   <= a_r[DW-1] ? -a_r : a_r;
               b_mag  <= b_r[WIDTH-1] ? -b_ext : b_ext;
               prem   <= '0;
               cnt    <= '0;
            end
            S_CALC: begin
               q_sh <= {q_sh[DW-2:0], ~trial[WIDTH+1]};
               prem <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
               cnt  <= cnt + CW'(1);
            end
            S_FIX: begin
               if (b_is_zero) begin
                  quot     <= '1;
                  rem      <= a_r[WIDTH-1:0];
                  div_zero <= 1'b1;
                  ovf      <= 1'b0;
               end else begin
                  quot     <= q_signed;
                  rem      <= r_signed;
                  div_zero <= 1'b0;
                  ovf      <= is_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq (WIDTH=6)
module tb_div_seq;

   localparam int W  = 6;
   localparam int DW = 12;
`ifdef DIV_EARLY_ZERO_EN
   localparam int ZLAT = 3;
`else
   localparam int ZLAT = 15;
`endif

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] a;
   logic [W-1:0]  b;
   logic [DW-1:0] quot;
   logic [W-1:0]  rem;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic          ovf;

   typedef struct packed {
      logic [DW-1:0] q;
      logic [W-1:0]  r;
      logic          dz;
      logic          ov;
   } exp_t;

   exp_t          sb_q[$];
   int            checks = 0;
   int            passes = 0;
   int            fails  = 0;
   int            rt_err = 0;
   logic [DW-1:0] last_quot = '0;
   bit            done_seen;

   div_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .quot     (quot),
      .rem      (rem),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [DW-1:0] aa, input logic [W-1:0] bb);
      exp_t e;
      int   sa;
      int   sd;
      sa = $signed(aa);
      sd = $signed(bb);
      e  = '0;
      if (sd == 0) begin
         e.q  = 12'hFFF;
         e.r  = aa[W-1:0];
         e.dz = 1'b1;
      end else if (sa == -2048 && sd == -1) begin
         e.q  = 12'h800;
         e.ov = 1'b1;
      end else begin
         e.q = 12'(sa / sd);
         e.r = 6'(sa % sd);
      end
      return e;
   endfunction

   task automatic issue(input logic [DW-1:0] aa, input logic [W-1:0] bb, input exp_t e);
      a     = aa;
      b     = bb;
      start = 1'b1;
      sb_q.push_back(e);
   endtask

   task automatic issue_m(input logic [DW-1:0] aa, input logic [W-1:0] bb);
      issue(aa, bb, model(aa, bb));
   endtask

   task automatic collect(input string tag, input int lat, input int pulse_at, input bit hold_chk);
      int   k;
      bit   bad;
      exp_t e;
      bad = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            if (hold_chk) chk({tag, "_hold_quot"}, quot, last_quot);
         end
         if (pulse_at > 0 && k == pulse_at - 1) begin
            start = 1'b1;
            a     = 12'h123;
            b     = 6'h05;
         end
         if (pulse_at > 0 && k == pulse_at) start = 1'b0;
         if (done === 1'b1) break;
         if (busy !== 1'b1) bad = 1'b1;
      end
      chk({tag, "_busy_window"}, bad, 0);
      chk({tag, "_latency"}, k, lat);
      chk({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      chk({tag, "_quot"}, quot, e.q);
      chk({tag, "_rem"}, rem, e.r);
      chk({tag, "_div_zero"}, div_zero, e.dz);
      chk({tag, "_ovf"}, ovf, e.ov);
      chk({tag, "_busy_in_done"}, busy, 0);
      last_quot = quot;
   endtask

   task automatic rt_op(input int x, input int y);
      exp_t e;
      bit   got;
      got = 1'b0;
      issue(12'(x * y), 6'(y), {12'(x), 6'd0, 1'b0, 1'b0});
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      e = sb_q.pop_front();
      if (!got || quot !== e.q || rem !== e.r || div_zero !== e.dz || ovf !== e.ov) rt_err++;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_quot"}, quot, 0);
      chk({tag, "_rem"}, rem, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_div_zero"}, div_zero, 0);
      chk({tag, "_ovf"}, ovf, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      issue_m(12'd100, 6'd7);
      collect("pos_pos", 15, 0, 1'b0);
      issue_m(12'hF9C, 6'd7);
      collect("neg_pos", 15, 0, 1'b0);
      issue_m(12'd100, 6'h39);
      collect("pos_neg", 15, 0, 1'b0);
      issue_m(12'hF9C, 6'h39);
      collect("neg_neg", 15, 0, 1'b0);
      issue_m(12'h800, 6'h3F);
      collect("ovf", 15, 0, 1'b0);
      issue_m(12'h800, 6'h20);
      collect("min_by_min", 15, 0, 1'b0);
      issue_m(12'd100, 6'd0);
      collect("div_zero", ZLAT, 0, 1'b0);
      issue_m(12'd2047, 6'd1);
      collect("max_by_one", 15, 0, 1'b0);

      issue_m(12'd100, 6'd7);
      collect("ignored_start", 15, 5, 1'b0);

      issue_m(12'd500, 6'd9);
      collect("b2b_first", 15, 0, 1'b0);
      issue_m(12'hE0C, 6'd9);
      collect("b2b_second", 15, 0, 1'b1);

      issue_m(12'd100, 6'd7);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk_zero_outputs("mid_reset");
      rst       = 1'b0;
      done_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      chk("mid_reset_no_done", done_seen, 0);
      sb_q.delete();
      issue_m(12'hF9C, 6'h39);
      collect("after_reset", 15, 0, 1'b0);

      for (int x = -31; x <= 31; x++) begin
         for (int y = -31; y <= 31; y++) begin
            if (y != 0) rt_op(x, y);
         end
      end
      chk("round_trip_errors", rt_err, 0);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential signed divider; the inverse operation of the combinational multiplier mul_top.
- Takes a 2*WIDTH-bit two's-complement dividend (the product width of mul_top) and a WIDTH-bit two's-complement divisor.
- Returns a truncated quotient and remainder after a fixed multi-cycle restoring-division sequence.
- Sits beside mul_top in the arithmetic datapath; supports a*b/b round-trip checking.

Parameters:
- WIDTH, 6, divisor/remainder width; dividend and quotient are 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy==0
- a  input  2*WIDTH  dividend, two's complement; captured on accepted start
- b  input  WIDTH  divisor, two's complement; captured on accepted start
- quot  output  2*WIDTH  quotient, two's complement, registered
- rem  output  WIDTH  remainder, two's complement, registered
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle pulse when quot/rem become valid
- div_zero  output  1  result flag: divisor was 0
- ovf  output  1  result flag: true quotient not representable

Behaviour:
- Reset: all outputs are 0, and the FSM goes to IDLE.
  - Reset applies on any clk edge with rst=1, including mid-operation; the in-flight operation is discarded with no done pulse.
- States and transitions:
  - IDLE -> PREP on start.
  - PREP (1 cycle): latch the signs, form |a| and |b| at 2*WIDTH and WIDTH+1 bits, clear the partial remainder.
  - CALC: exactly 2*WIDTH cycles, one quotient bit per cycle, MSB first. Each cycle: shift the partial remainder left, shift in the next |a| bit, trial-subtract |b|, and restore if the result is negative.
  - FIX (1 cycle): apply signs and register the outputs.
  - DONE (1 cycle, done=1) -> IDLE.
- Latency: start sampled at edge T gives busy=1 from T+1 through T+2*WIDTH+2, then done=1 and busy=0 at T+2*WIDTH+3 (T+15 for WIDTH=6).
- Start handling:
  - Start is accepted in IDLE and in DONE; a start in DONE re-enters PREP, giving back-to-back operations.
  - Start while busy=1 is ignored, and a/b are not recaptured.
- Output holding: quot, rem, div_zero and ovf hold their values from DONE until the FIX of the next operation; they are not cleared on start.
- Sign rules (truncate toward zero):
  - quot is negative iff sign(a) differs from sign(b) and quot is nonzero.
  - rem takes the sign of a; |rem| < |b|.
  - rem always fits WIDTH bits.
- Overflow:
  - a = -2^(2W-1) with b = -1 gives ovf=1 and quot = -2^(2W-1) (bit pattern 100...0), rem=0.
  - ovf=0 in all other cases.
- Divide by zero (b==0):
  - div_zero=1, quot = all ones, rem = a[WIDTH-1:0], ovf=0.
  - Timing is unchanged unless the optional feature is enabled.
- Magnitude of the most negative a or b is handled with one extra bit internally; no intermediate wraps.

Optional Feature:
- Macro: DIV_EARLY_ZERO_EN.
- Defined: b==0 is detected in PREP, and the FSM goes PREP -> FIX -> DONE, so done is at T+3. Outputs are as specified for divide by zero.
- Undefined: b==0 runs the full CALC sequence; FIX forces the divide-by-zero outputs, so done is at T+2*WIDTH+3.
- All non-zero-divisor behaviour is identical either way.

Test Plan:
- a=100, b=7, start at T -> done at T+15; quot=14, rem=2, div_zero=0, ovf=0; busy high T+1..T+14.
- a=-100 (12'hF9C), b=7 -> quot=-14 (12'hFF2), rem=-2 (6'h3E); a=100, b=-7 -> quot=12'hFF2, rem=2.
- a=-2048 (12'h800), b=-1 -> ovf=1, quot=12'h800, rem=0. Also a=-2048, b=-32 -> quot=64, rem=0, ovf=0.
- a=100, b=0 -> div_zero=1, quot=12'hFFF, rem=6'h24. Done at T+15 without DIV_EARLY_ZERO_EN, T+3 with it.
- Control boundaries:
  - Start pulsed at T+5 while busy -> ignored, original result delivered at T+15.
  - Start asserted in the DONE cycle -> second result at that cycle+15.
  - rst=1 at T+8 -> all outputs 0, no done pulse, next start behaves normally.
- Exhaustive round trip: every x,y in [-31,31] with y!=0, a = sign-extended x*y, b = y -> quot==x, rem==0, 0 errors reported.
